nios_entity_scan_ctrl: RTL and testbench

//  Avalon-MM slave controller that sequences a sweep over the game's entity-type lookup port.
//  On a CPU start command it issues one lookup per entity index and captures each 2-bit type

---
 rtl/nios_entity_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_nios_entity_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_entity_scan_ctrl.sv
// Avalon-MM slave that sweeps the entity-type lookup port once per start command,
// packing each entity's 2-bit type into a table word and counting active entities.
module nios_entity_scan_ctrl #(
    parameter int NUM_ENTITIES = 16,
    parameter int IDX_W        = 4,
    parameter int LOOKUP_LAT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             lookup_req,
    output logic [IDX_W-1:0] lookup_idx,
    input  logic [1:0]       lookup_type,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam logic [1:0]       ADDR_CTRL  = 2'd0;
    localparam logic [1:0]       ADDR_TABLE = 2'd1;
    localparam logic [1:0]       ADDR_COUNT = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ENTITIES - 1);
    // WAIT lasts LOOKUP_LAT-1 cycles; the counter is loaded in ISSUE and counts down to 0.
    localparam logic [3:0]       WAIT_LOAD  = (LOOKUP_LAT > 1) ? 4'(LOOKUP_LAT - 2) : 4'd0;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [3:0]       wait_cnt;
    logic [31:0]      scan_table;
    logic [4:0]       count;
    logic             done;
    logic             irq_en;
    logic             busy;
    logic             ctrl_wr;
    logic             start_cmd;
    logic             last_capture;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign busy         = (state != S_IDLE);
    assign ctrl_wr      = write && (address == ADDR_CTRL);
    assign start_cmd    = ctrl_wr && writedata[0] && !busy;
    assign last_capture = (state == S_CAPTURE) && (idx == LAST_IDX);
    assign lookup_req   = (state == S_ISSUE);
    assign lookup_idx   = idx;
    assign unused_wdata = ^writedata[31:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start_cmd) state_next = S_ISSUE;
            S_ISSUE:   state_next = (LOOKUP_LAT > 1) ? S_WAIT : S_CAPTURE;
            S_WAIT:    if (wait_cnt == 4'd0) state_next = S_CAPTURE;
            S_CAPTURE: state_next = last_capture ? S_IDLE : S_ISSUE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL:  rd_mux = {29'd0, done, irq_en, busy};
            ADDR_TABLE: rd_mux = scan_table;
            ADDR_COUNT: rd_mux = {27'd0, count};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            wait_cnt   <= '0;
            scan_table <= '0;
            count      <= '0;
            done       <= 1'b0;
            irq_en     <= 1'b0;
            irq        <= 1'b0;
            readdata   <= '0;
        end else begin
            if (ctrl_wr) irq_en <= writedata[1];

            if (start_cmd) begin
                idx        <= '0;
                scan_table <= '0;
                count      <= '0;
                done       <= 1'b0;
            end else if (ctrl_wr && writedata[2]) begin
                done <= 1'b0;
            end

            if (state == S_ISSUE) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (state == S_CAPTURE) begin
                scan_table[{idx, 1'b0} +: 2] <= lookup_type;
                count <= count + {4'd0, lookup_type != 2'b00};
                // NOTE: this later non-blocking write overrides clear_done above, so set wins.
                if (last_capture) begin
                    done <= 1'b1;
                    idx  <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end

            irq      <= done & irq_en;
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_nios_entity_scan_ctrl.sv
// Scoreboard bench for nios_entity_scan_ctrl: a 16x2 instance and a 5x1 instance,
// each fed by a lookup model returning type = idx % 4 exactly LOOKUP_LAT cycles after the request.
module tb_nios_entity_scan_ctrl;

    localparam int NI = 2;

    typedef struct {
        int          inst;
        int          tag;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        int inst;
        int idx;
        int cyc;
    } lk_exp_t;

    typedef struct {
        int   inst;
        logic val;
        int   cyc;
    } irq_exp_t;

    logic        clk = 1'b0;
    logic        reset      [NI];
    logic [1:0]  address    [NI];
    logic        write      [NI];
    logic [31:0] writedata  [NI];
    logic [31:0] readdata   [NI];
    logic        lookup_req [NI];
    logic [3:0]  lookup_idx [NI];
    logic [1:0]  lookup_type[NI];
    logic        irq        [NI];

    logic        rd_act     [NI];
    logic        irq_prev   [NI];
    rd_exp_t     rd_q[$];
    lk_exp_t     lk_q[$];
    irq_exp_t    irq_q[$];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int NE  = (gi == 0) ? 16 : 5;
        localparam int LAT = (gi == 0) ? 2 : 1;

        logic [15:0] pv;
        logic [3:0]  pidx [16];

        nios_entity_scan_ctrl #(
            .NUM_ENTITIES(NE),
            .IDX_W       (4),
            .LOOKUP_LAT  (LAT)
        ) dut (
            .clk        (clk),
            .reset      (reset[gi]),
            .address    (address[gi]),
            .write      (write[gi]),
            .writedata  (writedata[gi]),
            .readdata   (readdata[gi]),
            .lookup_req (lookup_req[gi]),
            .lookup_idx (lookup_idx[gi]),
            .lookup_type(lookup_type[gi]),
            .irq        (irq[gi])
        );

        // Lookup responder: data is valid only in the cycle LAT after the request, 2'b11 otherwise.
        always @(posedge clk) begin
            if (reset[gi]) pv <= '0;
            else           pv <= {pv[14:0], lookup_req[gi]};
            pidx[0] <= lookup_idx[gi];
            for (int k = 1; k < 16; k++) pidx[k] <= pidx[k-1];
        end

        assign lookup_type[gi] = pv[LAT-1] ? pidx[LAT-1][1:0] : 2'b11;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples just after each rising edge and pops whatever the DUT presented.
    always @(posedge clk) begin
        logic     rs [NI];
        rd_exp_t  re;
        lk_exp_t  le;
        irq_exp_t ie;
        for (int i = 0; i < NI; i++) rs[i] = rd_act[i];
        #1;
        for (int i = 0; i < NI; i++) begin
            if (rs[i]) begin
                if (rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL read_underflow_i%0d: got 0x%08h expected no read", i, readdata[i]);
                end else begin
                    re = rd_q.pop_front();
                    check($sformatf("read%0d_i%0d", re.tag, re.inst), readdata[i], re.val);
                end
            end
            if (lookup_req[i] === 1'b1) begin
                if (lk_q.size() == 0) begin
                    check($sformatf("unexpected_lookup_req_i%0d", i), 32'(lookup_req[i]), 32'd0);
                end else begin
                    le = lk_q.pop_front();
                    check($sformatf("lookup_idx_i%0d", le.inst), 32'(lookup_idx[i]), 32'(le.idx));
                    check($sformatf("lookup_cycle_i%0d_idx%0d", le.inst, le.idx), 32'(cyc), 32'(le.cyc));
                end
            end
            if (irq[i] !== irq_prev[i]) begin
                if (irq_q.size() == 0) begin
                    check($sformatf("unexpected_irq_edge_i%0d", i), 32'(irq[i]), 32'(irq_prev[i]));
                end else begin
                    ie = irq_q.pop_front();
                    check($sformatf("irq_level_i%0d", ie.inst), 32'(irq[i]), 32'(ie.val));
                    check($sformatf("irq_cycle_i%0d", ie.inst), 32'(cyc), 32'(ie.cyc));
                end
                irq_prev[i] = irq[i];
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            write[i]  = 1'b0;
            rd_act[i] = 1'b0;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic wr(input int i, input logic [1:0] a, input logic [31:0] d);
        address[i]   = a;
        writedata[i] = d;
        write[i]     = 1'b1;
    endtask

    task automatic rd(input int i, input logic [1:0] a, input logic [31:0] e, input int tag);
        address[i] = a;
        rd_act[i]  = 1'b1;
        rd_q.push_back('{inst: i, tag: tag, val: e});
    endtask

    task automatic start_scan(input int i, input logic [31:0] d, input int lat,
                              input int npulse, output int s);
        s = cyc;
        wr(i, 2'd0, d);
        for (int k = 0; k < npulse; k++)
            lk_q.push_back('{inst: i, idx: k, cyc: s + 1 + k * (lat + 1)});
    endtask

    initial begin
        int s;
        int w;
        for (int i = 0; i < NI; i++) begin
            reset[i]     = 1'b1;
            address[i]   = 2'd0;
            write[i]     = 1'b0;
            writedata[i] = '0;
            rd_act[i]    = 1'b0;
            irq_prev[i]  = 1'b0;
        end
        repeat (3) next_cycle();
        for (int i = 0; i < NI; i++) reset[i] = 1'b0;

        // 1: reset state of every address
        for (int a = 0; a < 4; a++) begin
            next_cycle();
            rd(0, 2'(a), 32'h0, 10 + a);
        end

        // 2: full scan, partial reads mid-scan, done timing at the 48-cycle boundary
        next_cycle();
        start_scan(0, 32'h1, 2, 16, s);
        goto(s + 12); rd(0, 2'd1, 32'h0000_0024, 20);
        next_cycle(); rd(0, 2'd2, 32'd3, 21);
        goto(s + 48); rd(0, 2'd0, 32'h1, 22);
        next_cycle(); rd(0, 2'd0, 32'h4, 23);
        next_cycle(); rd(0, 2'd1, 32'hE4E4_E4E4, 24);
        next_cycle(); rd(0, 2'd2, 32'd12, 25);

        // 3: irq follows done one cycle later, clear_done drops it
        next_cycle(); wr(0, 2'd0, 32'h6);
        next_cycle();
        start_scan(0, 32'h3, 2, 16, s);
        irq_q.push_back('{inst: 0, val: 1'b1, cyc: s + 50});
        goto(s + 49); rd(0, 2'd0, 32'h6, 30);
        goto(s + 52);
        w = cyc;
        wr(0, 2'd0, 32'h6);
        irq_q.push_back('{inst: 0, val: 1'b0, cyc: w + 2});
        next_cycle(); rd(0, 2'd0, 32'h2, 31);

        // 4: start while busy is ignored but irq_en updates; clear_done loses to final capture
        next_cycle();
        start_scan(0, 32'h1, 2, 16, s);
        goto(s + 16); wr(0, 2'd0, 32'h3);
        goto(s + 48); wr(0, 2'd0, 32'h6); rd(0, 2'd0, 32'h3, 40);
        irq_q.push_back('{inst: 0, val: 1'b1, cyc: s + 50});
        next_cycle(); rd(0, 2'd0, 32'h6, 41);
        next_cycle(); rd(0, 2'd1, 32'hE4E4_E4E4, 42);

        // 5: start+clear_done together, then reset at entity 9 and a clean rescan
        goto(cyc + 3);
        start_scan(0, 32'h5, 2, 10, s);
        irq_q.push_back('{inst: 0, val: 1'b0, cyc: s + 2});
        next_cycle(); rd(0, 2'd0, 32'h1, 50);
        goto(s + 29); reset[0] = 1'b1;
        next_cycle(); reset[0] = 1'b0;
        next_cycle(); rd(0, 2'd0, 32'h0, 51);
        next_cycle(); rd(0, 2'd1, 32'h0, 52);
        next_cycle(); rd(0, 2'd2, 32'h0, 53);
        goto(cyc + 10);
        start_scan(0, 32'h1, 2, 16, s);
        goto(s + 49); rd(0, 2'd0, 32'h4, 54);
        next_cycle(); rd(0, 2'd1, 32'hE4E4_E4E4, 55);
        next_cycle(); rd(0, 2'd2, 32'd12, 56);

        // 6: five entities at latency 1 on the second instance
        next_cycle();
        start_scan(1, 32'h1, 1, 5, s);
        goto(s + 10); rd(1, 2'd0, 32'h1, 60);
        next_cycle(); rd(1, 2'd0, 32'h4, 61);
        next_cycle(); rd(1, 2'd1, 32'h0000_00E4, 62);
        next_cycle(); rd(1, 2'd2, 32'd3, 63);

        repeat (4) next_cycle();
        check("pending_reads", 32'(rd_q.size()), 32'd0);
        check("pending_lookups", 32'(lk_q.size()), 32'd0);
        check("pending_irq_edges", 32'(irq_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
